apb_master_bridge: RTL and testbench

- Single-clock APB (AMBA 3 style) requester. Converts a simple local request interface (transfer strobe, direction, separate read and write address, write data) into APB SETUP/ACCESS phases toward one completer.
- Returns the read data captured from the completer to the local side.
- Sits between an internal controller and the APB peripheral bus.

---
 rtl/apb_master_bridge.sv | 93 +++++++++
 tb/tb_apb_master_bridge.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// APB requester bridge: turns local transfer requests into APB SETUP/ACCESS phases
// toward a single completer and returns the captured read data.
module apb_master_bridge #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  transfer,
    input  logic                  read_write,
    input  logic [ADDR_WIDTH-1:0] apb_read_add,
    input  logic [ADDR_WIDTH-1:0] apb_write_add,
    input  logic [DATA_WIDTH-1:0] apb_write_data,
    input  logic [DATA_WIDTH-1:0] pr_data,
    input  logic                  pready,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] padd,
    output logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] apb_read_data
);

    // Handshake: a transfer completes on a rising edge where psel=1, penable=1
    // and pready=1; pready is ignored in every other cycle.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t state, state_next;
    logic   enter_setup;
    logic   access_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (transfer) state_next = SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS:  if (pready) state_next = transfer ? SETUP : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        psel    = 1'b0;
        penable = 1'b0;
        case (state)
            SETUP:   psel = 1'b1;
            ACCESS:  begin
                psel    = 1'b1;
                penable = 1'b1;
            end
            default: ;
        endcase
    end

    assign access_done = (state == ACCESS) && pready;
    assign enter_setup = transfer && ((state == IDLE) || access_done);

    // Request fields are frozen for the whole transfer, wait states included.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwrite <= 1'b0;
            padd   <= '0;
            pwdata <= '0;
        end else if (enter_setup) begin
            pwrite <= read_write;
            padd   <= read_write ? apb_write_add : apb_read_add;
            if (read_write) begin
                pwdata <= apb_write_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            apb_read_data <= '0;
        end else if (access_done && !pwrite) begin
            apb_read_data <= pr_data;
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed vectors, a transfer-level
// reference model compared every cycle, plus literal checks at key points.
module tb_apb_master_bridge;

    logic       clk;
    logic       rst;
    logic       transfer;
    logic       read_write;
    logic [7:0] apb_read_add;
    logic [7:0] apb_write_add;
    logic [7:0] apb_write_data;
    logic [7:0] pr_data;
    logic       pready;
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] padd;
    logic [7:0] pwdata;
    logic [7:0] apb_read_data;

    int total = 0;
    int bad   = 0;
    bit checking = 0;

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    apb_master_bridge #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .transfer       (transfer),
        .read_write     (read_write),
        .apb_read_add   (apb_read_add),
        .apb_write_add  (apb_write_add),
        .apb_write_data (apb_write_data),
        .pr_data        (pr_data),
        .pready         (pready),
        .psel           (psel),
        .penable        (penable),
        .pwrite         (pwrite),
        .padd           (padd),
        .pwdata         (pwdata),
        .apb_read_data  (apb_read_data)
    );

    // Transfer-level model: a transfer is either not in progress, in its first
    // bus cycle, or in a later bus cycle waiting for the completer.
    bit       m_busy;
    bit       m_first;
    bit       m_pwrite;
    bit [7:0] m_padd;
    bit [7:0] m_pwdata;
    bit [7:0] m_rdata;

    task automatic m_start();
        m_busy   = 1;
        m_first  = 1;
        m_pwrite = read_write;
        m_padd   = read_write ? apb_write_add : apb_read_add;
        if (read_write) m_pwdata = apb_write_data;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_first = 0; m_pwrite = 0;
            m_padd = 0; m_pwdata = 0; m_rdata = 0;
        end else if (!m_busy) begin
            if (transfer) m_start();
        end else if (m_first) begin
            m_first = 0;
        end else if (pready) begin
            if (!m_pwrite) m_rdata = pr_data;
            if (transfer) m_start();
            else m_busy = 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard compare on the inactive edge
    always @(negedge clk) begin
        if (checking) begin
            chk("psel",          {31'd0, psel},    {31'd0, m_busy});
            chk("penable",       {31'd0, penable}, {31'd0, m_busy && !m_first});
            chk("pwrite",        {31'd0, pwrite},  {31'd0, m_pwrite});
            chk("padd",          {24'd0, padd},    {24'd0, m_padd});
            chk("pwdata",        {24'd0, pwdata},  {24'd0, m_pwdata});
            chk("apb_read_data", {24'd0, apb_read_data}, {24'd0, m_rdata});
        end
    end

    // Driver: advance n edges, landing 1 time unit after the last one
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1; transfer = 1; read_write = 0; pready = 1;
        apb_read_add = 0; apb_write_add = 0; apb_write_data = 0; pr_data = 0;
        cyc(1);
        checking = 1;
        cyc(1);
        chk("rst_psel",    {31'd0, psel}, 32'd0);
        chk("rst_penable", {31'd0, penable}, 32'd0);
        chk("rst_padd",    {24'd0, padd}, 32'd0);
        chk("rst_rdata",   {24'd0, apb_read_data}, 32'd0);

        // Zero-wait write
        rst = 0; transfer = 1; read_write = 1;
        apb_write_add = 8'hAB; apb_write_data = 8'hCD; pready = 1;
        cyc(1);
        chk("wr_setup_psel",    {31'd0, psel}, 32'd1);
        chk("wr_setup_penable", {31'd0, penable}, 32'd0);
        chk("wr_setup_pwrite",  {31'd0, pwrite}, 32'd1);
        chk("wr_setup_padd",    {24'd0, padd}, 32'hAB);
        chk("wr_setup_pwdata",  {24'd0, pwdata}, 32'hCD);
        transfer = 0;
        cyc(1);
        chk("wr_access_penable", {31'd0, penable}, 32'd1);
        cyc(1);
        chk("wr_idle_psel",  {31'd0, psel}, 32'd0);
        chk("wr_idle_rdata", {24'd0, apb_read_data}, 32'd0);

        // Read with three wait states
        transfer = 1; read_write = 0; apb_read_add = 8'hCD; pr_data = 8'hFF; pready = 0;
        cyc(1);
        transfer = 0;
        cyc(3);
        chk("rd_wait_penable", {31'd0, penable}, 32'd1);
        chk("rd_wait_padd",    {24'd0, padd}, 32'hCD);
        pready = 1;
        cyc(1);
        chk("rd_done_psel",  {31'd0, psel}, 32'd0);
        chk("rd_done_rdata", {24'd0, apb_read_data}, 32'hFF);

        // Back-to-back write then read
        transfer = 1; read_write = 1; apb_write_add = 8'hAB; apb_write_data = 8'hCD;
        cyc(1);
        read_write = 0; apb_read_add = 8'hCD; pr_data = 8'hFF;
        cyc(1);
        chk("b2b_access_penable", {31'd0, penable}, 32'd1);
        cyc(1);
        chk("b2b_setup_psel",    {31'd0, psel}, 32'd1);
        chk("b2b_setup_penable", {31'd0, penable}, 32'd0);
        chk("b2b_setup_padd",    {24'd0, padd}, 32'hCD);
        chk("b2b_setup_pwrite",  {31'd0, pwrite}, 32'd0);
        chk("b2b_setup_pwdata",  {24'd0, pwdata}, 32'hCD);
        transfer = 0;
        cyc(2);
        chk("b2b_rdata", {24'd0, apb_read_data}, 32'hFF);

        // Inputs change during a wait-stated write
        transfer = 1; read_write = 1; apb_write_add = 8'h11; apb_write_data = 8'h22;
        pready = 0; pr_data = 8'h99;
        cyc(1);
        apb_write_add = 8'h33; apb_write_data = 8'h44; apb_read_add = 8'h55; read_write = 0;
        cyc(3);
        chk("stab_padd",   {24'd0, padd}, 32'h11);
        chk("stab_pwdata", {24'd0, pwdata}, 32'h22);
        chk("stab_pwrite", {31'd0, pwrite}, 32'd1);
        pready = 1; transfer = 0;
        cyc(1);
        chk("stab_rdata_kept", {24'd0, apb_read_data}, 32'hFF);

        // Reset in the middle of an ACCESS
        transfer = 1; read_write = 0; apb_read_add = 8'h77; pready = 0;
        cyc(2);
        chk("mid_penable", {31'd0, penable}, 32'd1);
        rst = 1;
        cyc(1);
        chk("mid_rst_psel",   {31'd0, psel}, 32'd0);
        chk("mid_rst_padd",   {24'd0, padd}, 32'd0);
        chk("mid_rst_pwdata", {24'd0, pwdata}, 32'd0);
        chk("mid_rst_rdata",  {24'd0, apb_read_data}, 32'd0);
        rst = 0; transfer = 0;
        cyc(2);

        checking = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
